router_ctrl: RTL and testbench
==============================

Name: router_ctrl

Overview:
Packet-reception controller for the 1x3 router. Decodes the header address, sequences header/payload/parity writes into one of three output FIFOs, and stalls the source (busy) while the target FIFO is occupied or full. It also owns the per-FIFO valid outputs and the soft-reset timeout timers that flush an output FIFO when its consumer stops reading.

Parameters:
TIMEOUT, 30, cycles a non-empty FIFO may go unread before its soft_reset pulses
TW, 5, timer width; must satisfy 2^TW > TIMEOUT

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
pkt_valid  in  1  source asserts for header and payload bytes; low on the parity byte
data_in  in  2  header address bits [1:0]; sampled only in DECODE_ADDRESS
fifo_full  in  3  full flags of FIFO0..2
fifo_empty  in  3  empty flags of FIFO0..2
read_en  in  3  consumer read enables, FIFO0..2
parity_done  in  1  register block: parity byte captured
low_pkt_valid  in  1  register block: pkt_valid fell while stalled
busy  out  1  source must hold its current byte
detect_add  out  1  in DECODE_ADDRESS
lfd_state  out  1  in LOAD_FIRST_DATA
ld_state  out  1  in LOAD_DATA
laf_state  out  1  in LOAD_AFTER_FULL
full_state  out  1  in FIFO_FULL_STATE
rst_int_reg  out  1  in CHECK_PARITY_ERROR
we  out  3  one-hot FIFO write enable
vld_out  out  3  destination data available
soft_reset  out  3  one-cycle FIFO flush pulses

Behaviour:
- Moore FSM; state held in a register on the asynchronous reset. State-flag outputs and busy decode combinationally from the state.
- Reset: state=DECODE_ADDRESS, addr_r=0, timers=0, soft_reset=0. Outputs are therefore detect_add=1, all other state flags 0, busy=0 and we=0. vld_out follows ~fifo_empty.
- addr_r latches data_in when detect_add && pkt_valid && data_in!=3.
- sel: the address used to index the flag vectors. sel=data_in in DECODE_ADDRESS, addr_r otherwise. Flags are indexed by sel.
- DECODE_ADDRESS, busy=0:
  - pkt_valid && data_in==3: stay; the packet is dropped.
  - pkt_valid && fifo_empty[sel]: go to LOAD_FIRST_DATA.
  - pkt_valid && !fifo_empty[sel]: go to WAIT_TILL_EMPTY.
  - otherwise stay.
- WAIT_TILL_EMPTY, busy=1: go to LOAD_FIRST_DATA when fifo_empty[sel].
- LOAD_FIRST_DATA, busy=1, writes the header: unconditionally go to LOAD_DATA.
- LOAD_DATA, busy=0, writes payload:
  - fifo_full[sel]: go to FIFO_FULL_STATE.
  - else !pkt_valid: go to LOAD_PARITY.
  - else stay.
- FIFO_FULL_STATE, busy=1, no write: go to LOAD_AFTER_FULL when !fifo_full[sel].
- LOAD_AFTER_FULL, busy=1, writes the held byte:
  - parity_done: go to DECODE_ADDRESS.
  - else low_pkt_valid: go to LOAD_PARITY.
  - else go to LOAD_DATA.
- LOAD_PARITY, busy=1, writes parity: go to CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR, busy=1, no write:
  - fifo_full[sel]: go to FIFO_FULL_STATE.
  - else go to DECODE_ADDRESS.
- Write enable: write_enb = LOAD_FIRST_DATA | LOAD_DATA | LOAD_AFTER_FULL | LOAD_PARITY, and we = write_enb ? onehot(addr_r) : 3'b000.
  - In LOAD_DATA, we is additionally gated by !fifo_full[sel], so no write is issued into a full FIFO.
- Soft-reset priority: if soft_reset[addr_r] is 1 in any state other than DECODE_ADDRESS, next state is DECODE_ADDRESS. This overrides all other transitions, and the rest of the packet is lost.
- Timers, one per FIFO i, registered:
  - Clear to 0 when fifo_empty[i] || read_en[i].
  - Otherwise increment by 1.
  - When the timer equals TIMEOUT-1 and is still counting: assert soft_reset[i]=1 for exactly one cycle (the next cycle) and clear the timer.
  - A read in the same cycle as the terminal count wins: no pulse.
- vld_out[i] = ~fifo_empty[i], combinational.
- An asynchronous reset mid-packet returns immediately to the reset values. No partial write follows the reset deassertion.

Test Plan:
- Header 0x0D (len 3, addr 1), FIFO1 empty, 3 payload bytes, then parity with pkt_valid=0 -> state sequence DA,LFD,LD,LD,LD,LP,CPE,DA; we=3'b010 for 5 cycles; busy=0 only in DA/LD.
- Header addr 2 while fifo_empty[2]=0 -> WAIT_TILL_EMPTY with busy=1; raise fifo_empty[2] -> LFD next cycle, we=3'b100.
- Force fifo_full[0]=1 during LD -> FIFO_FULL_STATE, we=0, busy=1; release -> LAF, then LD (parity_done=0, low_pkt_valid=0) or DA (parity_done=1).
- Header with data_in=3 and pkt_valid=1 -> remains DA, we=0 throughout.
- FIFO2 non-empty and read_en[2]=0 for 30 cycles -> soft_reset[2] is a single pulse on cycle 31. Pulse during LD to addr 2 -> DA next cycle. Read on cycle 30 -> no pulse.
- Assert resetn=0 mid-LOAD_DATA -> detect_add=1, we=0, busy=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/router_ctrl.sv
// Packet-reception controller for the 1x3 router: header decode, FIFO write
// sequencing, source stall, per-FIFO valid outputs and read-timeout flush pulses.
module router_ctrl #(
   parameter int TIMEOUT = 30,
   parameter int TW      = 5
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       pkt_valid,
   input  logic [1:0] data_in,
   input  logic [2:0] fifo_full,
   input  logic [2:0] fifo_empty,
   input  logic [2:0] read_en,
   input  logic       parity_done,
   input  logic       low_pkt_valid,
   output logic       busy,
   output logic       detect_add,
   output logic       lfd_state,
   output logic       ld_state,
   output logic       laf_state,
   output logic       full_state,
   output logic       rst_int_reg,
   output logic [2:0] we,
   output logic [2:0] vld_out,
   output logic [2:0] soft_reset
);

   // state              | meaning
   // DECODE_ADDRESS     | idle, waiting for a header byte
   // WAIT_TILL_EMPTY    | header seen, target FIFO still holds data
   // LOAD_FIRST_DATA    | writing the header byte
   // LOAD_DATA          | writing payload bytes
   // FIFO_FULL_STATE    | target FIFO full, holding the current byte
   // LOAD_AFTER_FULL    | writing the byte held across the full condition
   // LOAD_PARITY        | writing the parity byte
   // CHECK_PARITY_ERROR | parity written, register block checks it
   typedef enum logic [2:0] {
      DECODE_ADDRESS,
      WAIT_TILL_EMPTY,
      LOAD_FIRST_DATA,
      LOAD_DATA,
      FIFO_FULL_STATE,
      LOAD_AFTER_FULL,
      LOAD_PARITY,
      CHECK_PARITY_ERROR
   } state_t;

   localparam logic [TW-1:0] TC = TW'(TIMEOUT - 1);

   state_t            state, state_nxt;
   logic [1:0]        addr_r;
   logic [1:0]        sel;
   logic [3:0]        empty_x, full_x, srst_x;
   logic [2:0][TW-1:0] timer;

   // pad the flag vectors so address 3 indexes a defined zero bit
   assign empty_x = {1'b0, fifo_empty};
   assign full_x  = {1'b0, fifo_full};
   assign srst_x  = {1'b0, soft_reset};
   assign sel     = (state == DECODE_ADDRESS) ? data_in : addr_r;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state  <= DECODE_ADDRESS;
         addr_r <= 2'd0;
      end else begin
         state <= state_nxt;
         if (detect_add && pkt_valid && (data_in != 2'd3))
            addr_r <= data_in;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         DECODE_ADDRESS: begin
            if (pkt_valid && (data_in != 2'd3))
               state_nxt = empty_x[sel] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
         end
         WAIT_TILL_EMPTY:
            if (empty_x[sel]) state_nxt = LOAD_FIRST_DATA;
         LOAD_FIRST_DATA:
            state_nxt = LOAD_DATA;
         LOAD_DATA: begin
            if (full_x[sel])     state_nxt = FIFO_FULL_STATE;
            else if (!pkt_valid) state_nxt = LOAD_PARITY;
         end
         FIFO_FULL_STATE:
            if (!full_x[sel]) state_nxt = LOAD_AFTER_FULL;
         LOAD_AFTER_FULL: begin
            if (parity_done)        state_nxt = DECODE_ADDRESS;
            else if (low_pkt_valid) state_nxt = LOAD_PARITY;
            else                    state_nxt = LOAD_DATA;
         end
         LOAD_PARITY:
            state_nxt = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR:
            state_nxt = full_x[sel] ? FIFO_FULL_STATE : DECODE_ADDRESS;
         default:
            state_nxt = DECODE_ADDRESS;
      endcase
      // a flush of the target FIFO abandons the rest of the packet
      if ((state != DECODE_ADDRESS) && srst_x[addr_r])
         state_nxt = DECODE_ADDRESS;
   end

   always_comb begin
      we = 3'b000;
      unique case (state)
         LOAD_FIRST_DATA, LOAD_AFTER_FULL, LOAD_PARITY:
            we = 3'b001 << addr_r;
         LOAD_DATA:
            if (!full_x[sel]) we = 3'b001 << addr_r;
         default: ;
      endcase
   end

   assign detect_add  = (state == DECODE_ADDRESS);
   assign lfd_state   = (state == LOAD_FIRST_DATA);
   assign ld_state    = (state == LOAD_DATA);
   assign laf_state   = (state == LOAD_AFTER_FULL);
   assign full_state  = (state == FIFO_FULL_STATE);
   assign rst_int_reg = (state == CHECK_PARITY_ERROR);
   assign busy        = !(detect_add || ld_state);
   assign vld_out     = ~fifo_empty;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         timer      <= '0;
         soft_reset <= 3'b000;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (fifo_empty[i] || read_en[i]) begin
               timer[i]      <= '0;
               soft_reset[i] <= 1'b0;
            end else if (timer[i] == TC) begin
               timer[i]      <= '0;
               soft_reset[i] <= 1'b1;
            end else begin
               timer[i]      <= timer[i] + 1'b1;
               soft_reset[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_router_ctrl.sv
// Scoreboard bench for router_ctrl: a packet-level reference model predicts the
// outputs of every cycle; a monitor compares them on the falling edge.
module tb_router_ctrl;
   localparam int TIMEOUT = 30;

   localparam int P_DA  = 0;
   localparam int P_WTE = 1;
   localparam int P_LFD = 2;
   localparam int P_LD  = 3;
   localparam int P_FFS = 4;
   localparam int P_LAF = 5;
   localparam int P_LP  = 6;
   localparam int P_CPE = 7;

   logic       clock = 1'b0;
   logic       resetn;
   logic       pkt_valid;
   logic [1:0] data_in;
   logic [2:0] fifo_full, fifo_empty, read_en;
   logic       parity_done, low_pkt_valid;
   logic       busy, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
   logic [2:0] we, vld_out, soft_reset;

   router_ctrl #(.TIMEOUT(TIMEOUT), .TW(5)) dut (
      .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_en(read_en),
      .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
      .busy(busy), .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
      .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
      .we(we), .vld_out(vld_out), .soft_reset(soft_reset)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic       busy;
      logic [5:0] flags;
      logic [2:0] we;
      logic [2:0] vld;
      logic [2:0] sr;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   int         m_ph;
   int         m_addr;
   int         m_unread [3];
   logic [2:0] m_sr;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
      end
   endtask

   task automatic model_reset();
      m_ph   = P_DA;
      m_addr = 0;
      m_sr   = 3'b000;
      for (int i = 0; i < 3; i++) m_unread[i] = 0;
   endtask

   // advance the model across one rising edge using the inputs held at that edge
   task automatic model_step();
      int a;
      int nxt;
      logic [2:0] sr_n;
      a   = (m_ph == P_DA) ? int'(data_in) : m_addr;
      nxt = m_ph;
      case (m_ph)
         P_DA:  if (pkt_valid && data_in != 2'd3) nxt = fifo_empty[a] ? P_LFD : P_WTE;
         P_WTE: if (fifo_empty[a]) nxt = P_LFD;
         P_LFD: nxt = P_LD;
         P_LD:  nxt = fifo_full[a] ? P_FFS : (!pkt_valid ? P_LP : P_LD);
         P_FFS: if (!fifo_full[a]) nxt = P_LAF;
         P_LAF: nxt = parity_done ? P_DA : (low_pkt_valid ? P_LP : P_LD);
         P_LP:  nxt = P_CPE;
         P_CPE: nxt = fifo_full[a] ? P_FFS : P_DA;
         default: nxt = P_DA;
      endcase
      if (m_ph != P_DA && m_sr[m_addr]) nxt = P_DA;
      if (m_ph == P_DA && pkt_valid && data_in != 2'd3) m_addr = int'(data_in);
      // flush fires once a FIFO has sat non-empty and unread for TIMEOUT cycles
      for (int i = 0; i < 3; i++) begin
         sr_n[i] = 1'b0;
         if (fifo_empty[i] || read_en[i]) m_unread[i] = 0;
         else begin
            m_unread[i]++;
            if (m_unread[i] == TIMEOUT) begin
               sr_n[i]     = 1'b1;
               m_unread[i] = 0;
            end
         end
      end
      m_sr = sr_n;
      m_ph = nxt;
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.busy  = !(m_ph == P_DA || m_ph == P_LD);
      e.flags = {m_ph == P_DA, m_ph == P_LFD, m_ph == P_LD, m_ph == P_LAF,
                 m_ph == P_FFS, m_ph == P_CPE};
      e.we    = 3'b000;
      if (m_ph == P_LFD || m_ph == P_LAF || m_ph == P_LP ||
          (m_ph == P_LD && !fifo_full[m_addr]))
         e.we = 3'(1 << m_addr);
      e.vld   = ~fifo_empty;
      e.sr    = m_sr;
      return e;
   endfunction

   task automatic cyc(input logic pv, input logic [1:0] din, input logic [2:0] full,
                      input logic [2:0] empty, input logic [2:0] rd,
                      input logic pd, input logic lpv);
      @(posedge clock);
      model_step();
      #1;
      pkt_valid     = pv;
      data_in       = din;
      fifo_full     = full;
      fifo_empty    = empty;
      read_en       = rd;
      parity_done   = pd;
      low_pkt_valid = lpv;
      exp_q.push_back(model_out());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
   endtask

   task automatic async_reset_check();
      @(negedge clock);
      #2;
      resetn = 1'b0;
      #1;
      chk("rst_detect_add", {7'd0, detect_add}, 8'd1);
      chk("rst_we", {5'd0, we}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_soft_reset", {5'd0, soft_reset}, 8'd0);
      model_reset();
      pkt_valid = 1'b0; fifo_full = 3'b000; fifo_empty = 3'b111; read_en = 3'b000;
      @(negedge clock);
      @(negedge clock);
      resetn = 1'b1;
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("busy", {7'd0, busy}, {7'd0, e.busy});
         chk("state_flags", {2'd0, detect_add, lfd_state, ld_state, laf_state, full_state,
                             rst_int_reg}, {2'd0, e.flags});
         chk("we", {5'd0, we}, {5'd0, e.we});
         chk("vld_out", {5'd0, vld_out}, {5'd0, e.vld});
         chk("soft_reset", {5'd0, soft_reset}, {5'd0, e.sr});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0;
      pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 3'b000; fifo_empty = 3'b111;
      read_en = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;
      model_reset();
      #3;
      chk("init_detect_add", {7'd0, detect_add}, 8'd1);
      chk("init_busy", {7'd0, busy}, 8'd0);
      @(negedge clock);
      @(negedge clock);
      resetn = 1'b1;

      // header addr 1, three payload bytes, parity
      idle(2);
      cyc(1, 2'd1, 3'b000, 3'b111, 3'b000, 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, 2'd0, 3'b000, 3'b101, 3'b000, 0, 0);
      cyc(0, 2'd0, 3'b000, 3'b101, 3'b000, 0, 0);
      idle(3);

      // addr 2 while FIFO2 holds data, then it drains
      cyc(1, 2'd2, 3'b000, 3'b011, 3'b000, 0, 0);
      cyc(1, 2'd2, 3'b000, 3'b011, 3'b100, 0, 0);
      cyc(1, 2'd2, 3'b000, 3'b011, 3'b100, 0, 0);
      cyc(1, 2'd2, 3'b000, 3'b111, 3'b000, 0, 0);
      cyc(1, 2'd0, 3'b000, 3'b011, 3'b100, 0, 0);
      cyc(0, 2'd0, 3'b000, 3'b011, 3'b100, 0, 0);
      idle(3);

      // FIFO0 full during payload, released into LAF -> LD, then LAF -> DA
      cyc(1, 2'd0, 3'b000, 3'b111, 3'b000, 0, 0);
      cyc(1, 2'd0, 3'b000, 3'b110, 3'b001, 0, 0);
      cyc(1, 2'd0, 3'b001, 3'b110, 3'b001, 0, 0);
      cyc(1, 2'd0, 3'b001, 3'b110, 3'b001, 0, 0);
      cyc(1, 2'd0, 3'b000, 3'b110, 3'b001, 0, 0);
      cyc(1, 2'd0, 3'b000, 3'b110, 3'b001, 0, 0);
      cyc(1, 2'd0, 3'b001, 3'b110, 3'b001, 0, 0);
      cyc(1, 2'd0, 3'b000, 3'b110, 3'b001, 0, 0);
      cyc(1, 2'd0, 3'b000, 3'b110, 3'b001, 1, 0);
      idle(3);

      // address 3 is dropped
      for (int i = 0; i < 3; i++) cyc(1, 2'd3, 3'b000, 3'b111, 3'b000, 0, 0);
      idle(2);

      // FIFO2 unread long enough to time out, then a read on the terminal cycle
      for (int i = 0; i < 34; i++) cyc(0, 2'd0, 3'b000, 3'b011, 3'b000, 0, 0);
      idle(1);
      for (int i = 0; i < 29; i++) cyc(0, 2'd0, 3'b000, 3'b011, 3'b000, 0, 0);
      cyc(0, 2'd0, 3'b000, 3'b011, 3'b100, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 2'd0, 3'b000, 3'b011, 3'b000, 0, 0);
      idle(2);

      // flush of FIFO2 while loading a packet to it
      cyc(1, 2'd2, 3'b000, 3'b111, 3'b000, 0, 0);
      for (int i = 0; i < 36; i++) cyc(1, 2'd1, 3'b000, 3'b011, 3'b000, 0, 0);
      idle(3);

      // asynchronous reset in the middle of a payload
      cyc(1, 2'd1, 3'b000, 3'b111, 3'b000, 0, 0);
      cyc(1, 2'd0, 3'b000, 3'b101, 3'b000, 0, 0);
      cyc(1, 2'd0, 3'b000, 3'b101, 3'b000, 0, 0);
      async_reset_check();
      idle(3);

      // randomized traffic
      for (int i = 0; i < 700; i++) begin
         logic [2:0] emp, ful, rd;
         for (int b = 0; b < 3; b++) begin
            emp[b] = ($urandom_range(0, 3) != 0);
            ful[b] = ($urandom_range(0, 7) == 0);
            rd[b]  = ($urandom_range(0, 3) == 0);
         end
         cyc(logic'($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)), ful, emp, rd,
             logic'($urandom_range(0, 5) == 0), logic'($urandom_range(0, 5) == 0));
      end
      idle(2);

      @(negedge clock);
      #1;
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
